fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined core, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues in-order requests to the instruction memory over a request/grant/response handshake. Returned instructions go into a 2-entry buffer, which presents instruction, PC and PC+4 to the IF/ID register. It honours hazard-unit stalls and redirects from branch/jump resolution, discarding wrong-path responses still in flight.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction memory request/grant/response bus.
// master: fetch side drives imem_req/imem_addr, receives grant and in-order responses.
// slave : memory side.
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests,
// buffers up to 2 returned instructions and presents the head to IF/ID.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   StallF             downstream not accepting (head held)
//   Redirect/RedirectPC flush buffer and refetch from RedirectPC (word aligned)
//   imem               instruction memory bus (master side)
//   InstrF/PCF/PC_PlusF/ValidF  registered buffer head
module fetch_unit #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  input  logic                  Redirect,
  input  logic [DATA_WIDTH-1:0] RedirectPC,
  fetch_unit_if.master          imem,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PC_PlusF,
  output logic                  ValidF
);

  localparam logic [DATA_WIDTH-1:0] NOP   = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] WORD  = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN = ~DATA_WIDTH'(3);

  // Registered state
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] tail_instr_q, tail_instr_d;
  logic [DATA_WIDTH-1:0] tail_pc_q, tail_pc_d;
  logic                  tail_valid_q, tail_valid_d;
  logic [DATA_WIDTH-1:0] pcq0_q, pcq0_d, pcq1_q, pcq1_d;
  logic [1:0]            outst_q, outst_d;
  logic [1:0]            discard_q, discard_d;
  logic [DATA_WIDTH-1:0] instr_d, pc_d, pcp_d;
  logic                  valid_d;

  // Combinational helpers
  logic       pop, resp, keep, grant;
  logic [1:0] count, remaining;
  logic [2:0] credit;

  // Next-state and request logic
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_valid_d = tail_valid_q;
    pcq0_d       = pcq0_q;
    pcq1_d       = pcq1_q;
    outst_d      = outst_q;
    discard_d    = discard_q;
    instr_d      = InstrF;
    pc_d         = PCF;
    pcp_d        = PC_PlusF;
    valid_d      = ValidF;

    pop    = ValidF && !StallF;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp   = imem.imem_rvalid && (outst_q != 2'd0);
    keep   = resp && (discard_q == 2'd0) && !Redirect;
    count  = 2'(ValidF) + 2'(tail_valid_q);
    credit = 3'(count) + 3'(outst_q);

    // Credit check written as credit < 2 + pop to stay unsigned.
    imem.imem_req  = !Redirect && (credit < (3'd2 + 3'(pop)));
    imem.imem_addr = fetch_pc_q;
    grant          = imem.imem_req && imem.imem_gnt;

    outst_d   = outst_q + 2'(grant) - 2'(resp);
    remaining = outst_q - 2'(resp);

    // Outstanding-address queue: shift on response, append on grant.
    if (resp) pcq0_d = pcq1_q;
    if (grant) begin
      if (remaining == 2'd0) pcq0_d = fetch_pc_q;
      else                   pcq1_d = fetch_pc_q;
    end

    if (grant) fetch_pc_d = fetch_pc_q + WORD;

    if (Redirect) begin
      fetch_pc_d   = RedirectPC & ALIGN;
      // Everything still in flight (minus this cycle's response) is wrong-path.
      discard_d    = remaining;
      valid_d      = 1'b0;
      instr_d      = NOP;
      pc_d         = '0;
      pcp_d        = '0;
      tail_valid_d = 1'b0;
    end else begin
      if (resp && (discard_q != 2'd0)) discard_d = discard_q - 2'd1;

      // Pop first, then push into the first free slot.
      if (pop) begin
        if (tail_valid_q) begin
          valid_d      = 1'b1;
          instr_d      = tail_instr_q;
          pc_d         = tail_pc_q;
          pcp_d        = tail_pc_q + WORD;
          tail_valid_d = 1'b0;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP;
          pc_d    = '0;
          pcp_d   = '0;
        end
      end

      if (keep) begin
        if (valid_d) begin
          tail_valid_d = 1'b1;
          tail_instr_d = imem.imem_rdata;
          tail_pc_d    = pcq0_q;
        end else begin
          valid_d = 1'b1;
          instr_d = imem.imem_rdata;
          pc_d    = pcq0_q;
          pcp_d   = pcq0_q + WORD;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_valid_q <= 1'b0;
      pcq0_q       <= '0;
      pcq1_q       <= '0;
      outst_q      <= 2'd0;
      discard_q    <= 2'd0;
      InstrF       <= NOP;
      PCF          <= '0;
      PC_PlusF     <= '0;
      ValidF       <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_valid_q <= tail_valid_d;
      pcq0_q       <= pcq0_d;
      pcq1_q       <= pcq1_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      InstrF       <= instr_d;
      PCF          <= pc_d;
      PC_PlusF     <= pcp_d;
      ValidF       <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory with variable latency
// plus a queue-based reference model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        StallF;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] InstrF, PCF, PC_PlusF;
  logic        ValidF;

  fetch_unit_if #(.DATA_WIDTH(32)) bus ();

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .imem       (bus),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .PC_PlusF   (PC_PlusF),
    .ValidF     (ValidF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit wrong; }         infl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } bent_t;
  typedef struct { logic [31:0] addr; int due; }          mreq_t;

  infl_t infl[$];   // model: requests granted, not yet answered
  bent_t mbuf[$];   // model: instruction buffer
  mreq_t memq[$];   // memory: pending responses
  logic [31:0] mfetch;
  int cyc, last_due, k_lat;
  int n_chk, n_bad;

  function automatic logic [31:0] memfunc(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance.
  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc, input bit gnt);
    bit resp, pop, exp_req, grant_d, grant_m;
    int due;
    infl_t e;
    bent_t b;
    resp = (memq.size() > 0) && (memq[0].due <= cyc);
    StallF          = stall;
    Redirect        = redir;
    RedirectPC      = rpc;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = resp;
    bus.imem_rdata  = resp ? memfunc(memq[0].addr) : $urandom;
    #1;
    if (mbuf.size() > 0) begin
      chk("valid", ValidF, 1);
      chk("instr", InstrF, mbuf[0].instr);
      chk("pc",    PCF, mbuf[0].pc);
      chk("pcplus", PC_PlusF, mbuf[0].pc + 32'd4);
    end else begin
      chk("valid", ValidF, 0);
      chk("instr_nop", InstrF, 32'h13);
      chk("pc_zero", PCF, 0);
      chk("pcplus_zero", PC_PlusF, 0);
    end
    pop     = (mbuf.size() > 0) && !stall;
    exp_req = !redir && ((mbuf.size() + infl.size() - int'(pop)) < 2);
    chk("req", bus.imem_req, exp_req);
    if (exp_req) chk("addr", bus.imem_addr, mfetch);
    // memory side follows the DUT's actual handshake
    grant_d = bus.imem_req && gnt;
    if (resp) void'(memq.pop_front());
    if (grant_d) begin
      due = cyc + k_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: bus.imem_addr, due: due});
    end
    chk("outstanding_le2", memq.size() <= 2, 1);
    // reference model update
    grant_m = exp_req && gnt;
    if (pop) void'(mbuf.pop_front());
    if (resp && infl.size() > 0) begin
      e = infl.pop_front();
      if (!e.wrong && !redir) begin
        b.instr = memfunc(e.pc);
        b.pc    = e.pc;
        mbuf.push_back(b);
      end
    end
    if (redir) begin
      mbuf.delete();
      foreach (infl[i]) infl[i].wrong = 1'b1;
      mfetch = rpc & ~32'd3;
    end else if (grant_m) begin
      infl.push_back('{pc: mfetch, wrong: 1'b0});
      mfetch = mfetch + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    StallF = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    infl.delete(); mbuf.delete(); memq.delete();
    mfetch = RESET_PC; cyc = 0; last_due = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ValidF, 0);
    chk("rst_instr", InstrF, 32'h13);
    chk("rst_pc", PCF, 0);
    chk("rst_pcplus", PC_PlusF, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    n_chk = 0; n_bad = 0; k_lat = 1;

    // Streaming after reset, k=1, always granted
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (cyc == 2) begin
        chk("first_valid", ValidF, 1);
        chk("first_pc", PCF, RESET_PC);
        chk("first_pcplus", PC_PlusF, RESET_PC + 32'd4);
      end
      step(0, 0, 0, 1);
    end

    // Stall for 3 cycles, then release
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    chk("stall_req_low", bus.imem_req, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // Redirect to 0x103 with 2 outstanding (k=3)
    k_lat = 3;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (infl.size() == 2) done = 1;
      else step(0, 0, 0, 1);
    end
    chk("two_outstanding_reached", done, 1);
    step(0, 1, 32'h0000_0103, 1);
    chk("redir_cleared", ValidF, 0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (ValidF) done = 1;
      else step(0, 0, 0, 1);
    end
    chk("redir_valid_seen", done, 1);
    chk("redir_first_pc", PCF, 32'h0000_0100);
    chk("redir_first_pcplus", PC_PlusF, 32'h0000_0104);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Redirect coinciding with a response while stalled
    k_lat = 2;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && infl.size() >= 1) done = 1;
      else step(1, 0, 0, 1);
    end
    chk("resp_redirect_setup", done, 1);
    step(1, 1, 32'h0000_0200, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    // Grant withheld 4 cycles, then k=3 memory
    do_reset();
    k_lat = 3;
    for (int i = 0; i < 4; i++) begin
      chk("ungranted_addr_stable", bus.imem_addr, RESET_PC);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 1);            // grant of RESET_PC
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("k3_not_yet_valid", ValidF, 0);
    step(0, 0, 0, 1);
    chk("k3_valid_after_4", ValidF, 1);
    chk("k3_pc", PCF, RESET_PC);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 49) == 0) k_lat = $urandom_range(1, 4);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF9 : $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, rpc,
           $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-stream with 2 buffered entries
    k_lat = 1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mbuf.size() == 2) done = 1;
      else step(1, 0, 0, 1);
    end
    chk("two_buffered_reached", done, 1);
    chk("pre_reset_valid", ValidF, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ValidF, 0);
    chk("async_rst_instr", InstrF, 32'h13);
    chk("async_rst_pc", PCF, 0);
    chk("async_rst_pcplus", PC_PlusF, 0);
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
